ff_add_mod: RTL
===============

Name: ff_add_mod

Overview:
- Multi-cycle modular adder over GF(p), p = 2^255 - 19. It is the additive counterpart of the team's field subtractor.
- Computes out = (a_i + b_i) mod p, one 64-bit limb per cycle.
- Uses one 64-bit adder chain for a+b, and one 64-bit subtractor chain for the trial reduction (a+b) - p, running one limb behind the adder.
- Sits beside the subtractor under the point add/double sequencer, with the same start/done handshake.

Parameters:
- LIMB_W, 64, limb width in bits; fixed, 256/LIMB_W = 4 limbs.
- P, 2^255 - 19 (256-bit), field modulus.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_i  input  255  operand A, canonical (< p).
- b_i  input  255  operand B, canonical (< p).
- out  output  255  registered result (a_i + b_i) mod p.
- done  output  1  one-cycle pulse: out valid.
- err  output  1  only with FF_ADD_STRICT_EN; see Optional Feature.

Behaviour:
- Reset is asynchronous and active-high. All state clears: state=IDLE, done=0, out=0, err=0, internal sum/diff/carry/borrow registers cleared.
- Reset mid-operation aborts the operation. No done pulse is produced for the aborted request.
- States: IDLE, C1, C2, C3, C4, C5, C6. Each non-IDLE state lasts exactly 1 cycle.
- IDLE: done=0 unless arriving from C6. On start=1, latch {1'b0,a_i} and {1'b0,b_i} into internal 256-bit registers and go to C1. Inputs may change after the accepting edge.
- C1: s[63:0] = a[63:0] + b[63:0], carry-in 0; register carry.
- C2: add limb 1 with carry. Subtract limb 0: d[63:0] = s[63:0] - P[63:0], borrow-in 0.
- C3: add limb 2; subtract limb 1 with borrow.
- C4: add limb 3; subtract limb 2.
- C5: subtract limb 3; register final borrow.
- C6: out <= final_borrow ? s[254:0] : d[254:0]; done <= 1; go to IDLE.
- Latency: start sampled at edge E0, done and out update at edge E6. done is high for exactly the cycle after E6.
- Back-to-back: done is asserted while in IDLE, so start=1 in that cycle is accepted. Minimum issue interval is 7 cycles.
- start while not IDLE is ignored: no queueing and no effect on the in-flight operation.
- out holds its value until the next C6 or reset.
- Arithmetic:
  - Canonical inputs give a+b ≤ 2p-2 < 2^256, so no carry leaves limb 3.
  - Borrow from limb 3 set means a+b < p: select s. Otherwise select d = a+b-p.
  - Result is always < p for canonical inputs.
- Non-canonical inputs (≥ p) are outside contract without FF_ADD_STRICT_EN. The result is then (a+b) or (a+b-p) truncated to 255 bits, with no correction.

Optional Feature:
- Macro: FF_ADD_STRICT_EN.
- Defined:
  - Port err exists.
  - In IDLE on accept, register flag = (a_i ≥ p) | (b_i ≥ p).
  - At C6, err <= flag together with done. err holds until the next C6 or reset.
  - out is computed identically either way.
- Undefined: no err port, no comparator logic. Behaviour is otherwise identical.

Test Plan:
- a=1, b=2, start pulse at E0 -> done=1 only in cycle after E6, out=3; done low at all other cycles.
- a=p-1, b=1 -> out=0 (exact wrap). a=p-1, b=p-1 -> out=p-2.
- a=2^64-1, b=1 -> out=2^64 (carry crosses limb 0->1). a=2^192-1, b=1 -> out=2^192.
- Back-to-back: start held high. Op1 a=5,b=6, op2 a=p-2,b=3 applied when done high -> out=11, then 7 cycles later out=1; start pulses mid-op ignored.
- Reset mid-op: start at E0, rst asserted between E3 and E4 -> done never pulses, out=0; next start with a=10,b=20 -> out=30 after 6 cycles.
- With FF_ADD_STRICT_EN: a=p, b=0 -> err=1 with done. a=p-1, b=0 -> err=0, out=p-1.

Source files
------------

// File: rtl/ff_add_mod.sv
// ff_add_mod: multi-cycle modular adder over GF(2^255 - 19).
// One 64-bit adder chain produces s = a + b limb by limb. A 64-bit subtractor
// chain, running one limb behind, produces d = s - p. The final borrow picks
// s (a + b < p) or d (a + b >= p).
// Optional build macro FF_ADD_STRICT_EN adds the err output. err flags
// non-canonical operands (>= p) and is reported together with done.
module ff_add_mod (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [254:0] a_i,
    input  logic [254:0] b_i,
    output logic [254:0] out,
    output logic         done
`ifdef FF_ADD_STRICT_EN
    ,
    output logic         err
`endif
);

    localparam int LIMB_W = 64;
    localparam logic [255:0] P =
        256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;

    typedef enum logic [2:0] {IDLE, C1, C2, C3, C4, C5, C6} state_t;

    state_t state_q, state_d;

    logic [255:0] a_q, b_q, s_q;
    logic [254:0] d_q;
    logic         carry_q, borrow_q;
    logic [254:0] out_q;
    logic         done_q;

    logic               add_en, sub_en;
    logic [1:0]         add_idx, sub_idx;
    logic [LIMB_W:0]    add_res, sub_res;
    logic [LIMB_W-1:0]  a_limb, b_limb, s_limb, p_limb;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and per-state limb selection for the two arithmetic chains
    always_comb begin
        state_d = state_q;
        add_en  = 1'b0;
        sub_en  = 1'b0;
        add_idx = 2'd0;
        sub_idx = 2'd0;
        case (state_q)
            IDLE: if (start) state_d = C1;
            C1: begin state_d = C2; add_en = 1'b1; add_idx = 2'd0; end
            C2: begin state_d = C3; add_en = 1'b1; add_idx = 2'd1;
                      sub_en = 1'b1; sub_idx = 2'd0; end
            C3: begin state_d = C4; add_en = 1'b1; add_idx = 2'd2;
                      sub_en = 1'b1; sub_idx = 2'd1; end
            C4: begin state_d = C5; add_en = 1'b1; add_idx = 2'd3;
                      sub_en = 1'b1; sub_idx = 2'd2; end
            C5: begin state_d = C6; sub_en = 1'b1; sub_idx = 2'd3; end
            C6: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One limb of the adder and one limb of the trial subtraction.
    // The subtractor reads the s limb that the adder wrote in the previous cycle.
    always_comb begin
        a_limb  = a_q[{add_idx, 6'd0} +: LIMB_W];
        b_limb  = b_q[{add_idx, 6'd0} +: LIMB_W];
        s_limb  = s_q[{sub_idx, 6'd0} +: LIMB_W];
        p_limb  = P[{sub_idx, 6'd0} +: LIMB_W];
        add_res = {1'b0, a_limb} + {1'b0, b_limb} + {{LIMB_W{1'b0}}, carry_q};
        sub_res = {1'b0, s_limb} - {1'b0, p_limb} - {{LIMB_W{1'b0}}, borrow_q};
    end

`ifdef FF_ADD_STRICT_EN
    logic flag_q, err_q;

    // Latch the non-canonical operand flag on accept; report it at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && start)
                flag_q <= ({1'b0, a_i} >= P) | ({1'b0, b_i} >= P);
            if (state_q == C6)
                err_q <= flag_q;
        end
    end

    assign err = err_q;
`endif

    // Operand capture, limb-serial sum/difference, and final selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            d_q      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            out_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE && start) begin
                a_q      <= {1'b0, a_i};
                b_q      <= {1'b0, b_i};
                carry_q  <= 1'b0;
                borrow_q <= 1'b0;
            end
            if (add_en) begin
                s_q[{add_idx, 6'd0} +: LIMB_W] <= add_res[LIMB_W-1:0];
                carry_q <= add_res[LIMB_W];
            end
            if (sub_en) begin
                case (sub_idx)
                    2'd0:    d_q[63:0]    <= sub_res[63:0];
                    2'd1:    d_q[127:64]  <= sub_res[63:0];
                    2'd2:    d_q[191:128] <= sub_res[63:0];
                    default: d_q[254:192] <= sub_res[62:0];
                endcase
                borrow_q <= sub_res[LIMB_W];
            end
            if (state_q == C6) begin
                // Final borrow set means a + b < p, so the unreduced sum is the result
                out_q  <= borrow_q ? s_q[254:0] : d_q;
                done_q <= 1'b1;
            end
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule
